// File: rtl/load_store_unit.sv
// MIPS byte/half/word load-store unit: IDLE -> ACCESS -> RESP, big-endian lanes.
// Define LSU_TIMEOUT_EN to abort an unacknowledged access after TIMEOUT_CYCLES.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t      state_q, state_d;
    // {store, size[1:0]}: size 00 byte, 01 half, 11 word
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] ld_q, ld_d;
    logic        err_q, err_d;

    logic        in_mem, in_mis;
    logic [3:0]  be;
    logic [31:0] wdata, ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        in_mem = 1'b0;
        in_mis = 1'b0;
        case (opcode)
            OP_LB, OP_SB: in_mem = 1'b1;
            OP_LH, OP_SH: begin
                in_mem = 1'b1;
                in_mis = addr[0];
            end
            OP_LW, OP_SW: begin
                in_mem = 1'b1;
                in_mis = |addr[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        be      = 4'b1111;
        wdata   = sdata_q;
        ext     = mem_rdata;
        rd_half = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (addr_q[1:0])
            2'd0:    rd_byte = mem_rdata[31:24];
            2'd1:    rd_byte = mem_rdata[23:16];
            2'd2:    rd_byte = mem_rdata[15:8];
            default: rd_byte = mem_rdata[7:0];
        endcase
        case (op_q[1:0])
            2'b00: begin
                if (op_q[2]) be = 4'b1000 >> addr_q[1:0];
                wdata = {4{sdata_q[7:0]}};
                ext   = {{24{rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                if (op_q[2]) be = addr_q[1] ? 4'b0011 : 4'b1100;
                wdata = {2{sdata_q[15:0]}};
                ext   = {{16{rd_half[15]}}, rd_half};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        ld_d    = ld_q;
        err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = {opcode[3], opcode[1:0]};
                    addr_d  = addr;
                    sdata_d = store_data;
                    err_d   = in_mis;
                    state_d = (in_mem && !in_mis) ? S_ACCESS : S_RESP;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    if (!op_q[2]) ld_d = ext;
                    state_d = S_RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_RESP);
    assign err       = done && err_q;
    assign load_data = ld_q;
    assign mem_req   = (state_q == S_ACCESS);
    assign mem_we    = mem_req && op_q[2];
    assign mem_be    = mem_req ? be : 4'b0000;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-lane reference model.
// Build with +define+LSU_TIMEOUT_EN to also exercise the access timeout.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .err(err), .load_data(load_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          has_mem;
        logic [31:0] maddr;
        logic [3:0]  be;
        bit          we;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] ld;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] model_ld = '0;
    bit          req_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, expv, cyc);
        end
    endtask

    // Reference model: works from the opcode table and byte-lane arithmetic.
    task automatic model(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input bit timeout, output exp_t e);
        int  off, size;
        bit  is_mem, is_st, mis;
        logic [31:0] v;
        off    = int'(a % 4);
        is_mem = 1;
        is_st  = 0;
        size   = 4;
        case (op)
            6'h20: size = 1;
            6'h21: size = 2;
            6'h23: size = 4;
            6'h28: begin size = 1; is_st = 1; end
            6'h29: begin size = 2; is_st = 1; end
            6'h2B: begin size = 4; is_st = 1; end
            default: is_mem = 0;
        endcase
        mis       = is_mem && (off % size != 0);
        e.has_mem = is_mem && !mis;
        e.err     = mis || (e.has_mem && timeout);
        e.maddr   = a - off;
        e.we      = is_st;
        e.be      = 4'hF;
        e.wdata   = sd;
        if (is_st && size == 1) begin
            e.be    = 4'(1 << (3 - off));
            e.wdata = (sd & 32'hFF) * 32'h01010101;
        end else if (is_st && size == 2) begin
            e.be    = (off == 0) ? 4'hC : 4'h3;
            e.wdata = (sd & 32'hFFFF) * 32'h00010001;
        end
        if (e.has_mem && !is_st && !timeout) begin
            if (size == 1) begin
                v = (rd >> (8 * (3 - off))) & 32'hFF;
                if (v >= 128) v = v + 32'hFFFFFF00;
            end else if (size == 2) begin
                v = (rd >> (16 * (1 - off / 2))) & 32'hFFFF;
                if (v >= 32768) v = v + 32'hFFFF0000;
            end else begin
                v = rd;
            end
            model_ld = v;
        end
        e.ld = model_ld;
    endtask

    // delay < 0 withholds the ack entirely.
    task automatic txn(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd,
                       input int delay, input bit junk);
        exp_t e;
        model(op, a, sd, rd, delay < 0, e);
        opcode     = op;
        addr       = a;
        store_data = sd;
        mem_rdata  = $urandom;
        start      = 1'b1;
        @(posedge clk);
        #1;
        e.done_cyc = !e.has_mem ? cyc : (delay < 0 ? cyc + TO : cyc + 1 + delay);
        exp_q.push_back(e);
        start      = 1'b0;
        opcode     = 6'($urandom);
        addr       = $urandom;
        store_data = $urandom;
        if (e.has_mem) begin
            if (delay >= 0) begin
                for (int i = 0; i < delay; i++) begin
                    start = junk ? 1'($urandom) : 1'b0;
                    @(posedge clk);
                    #1;
                    mem_rdata = $urandom;
                end
                start     = 1'b0;
                mem_rdata = rd;
                mem_ack   = 1'b1;
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end else begin
                repeat (TO) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        start = junk;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            req_seen = 0;
        end else begin
            if (mem_req) begin
                if (exp_q.size() == 0 || !exp_q[0].has_mem) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_req: got mem_req=1 expected 0 at cycle %0d", cyc);
                end else begin
                    req_seen = 1;
                    chk("mem_addr", mem_addr, exp_q[0].maddr);
                    chk("mem_be", 32'(mem_be), 32'(exp_q[0].be));
                    chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
                    if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                end
            end else begin
                chk("idle_we", 32'(mem_we), 32'd0);
                chk("idle_be", 32'(mem_be), 32'd0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_done: got done=1 expected 0 at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("err", 32'(err), 32'(e.err));
                    chk("load_data", load_data, e.ld);
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    chk("req_issued", 32'(req_seen), 32'(e.has_mem));
                    chk("resp_busy", 32'(busy), 32'd1);
                    req_seen = 0;
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        opcode     = '0;
        addr       = '0;
        store_data = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_load", load_data, 32'd0);
        reset = 1'b0;

        txn(6'h20, 32'h00000101, 32'h0, 32'h12F45678, 0, 0);
        chk("lb_sext", load_data, 32'hFFFFFFF4);
        txn(6'h29, 32'h00000202, 32'h0000ABCD, 32'h0, 1, 0);
        txn(6'h23, 32'h00000006, 32'h0, 32'h0, 0, 0);
        txn(6'h21, 32'h00000012, 32'h0, 32'h8001CAFE, 5, 1);
        txn(6'h23, 32'h00000040, 32'h0, 32'h0BADF00D, 5, 1);
        chk("lw_pass", load_data, 32'h0BADF00D);
        txn(6'h0F, 32'h00000000, 32'h0, 32'h0, 0, 1);
        chk("nonmem_hold", load_data, 32'h0BADF00D);

        // Reset while the unit is waiting in ACCESS.
        txn_abort();
        txn(6'h2B, 32'h00000080, 32'h13579BDF, 32'h0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] op;
            int k;
            logic [5:0] ops [6] = '{6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B};
            k  = $urandom_range(0, 7);
            op = (k < 6) ? ops[k] : 6'($urandom);
            txn(op, $urandom, $urandom, $urandom, $urandom_range(0, 4),
                1'($urandom));
        end

`ifdef LSU_TIMEOUT_EN
        txn(6'h23, 32'h00000100, 32'h0, 32'h0, -1, 1);
        txn(6'h2B, 32'h00000104, 32'hCAFEBABE, 32'h0, 0, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic txn_abort();
        exp_t e;
        model(6'h23, 32'h00000040, 32'h0, 32'h0, 1, e);
        e.done_cyc = 0;
        opcode = 6'h23;
        addr   = 32'h00000040;
        start  = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_be", 32'(mem_be), 32'd0);
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_load", load_data, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_wdata", mem_wdata, 32'd0);
        exp_q.delete();
        model_ld = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

endmodule
